// File: rtl/pio_cond_pkg.sv
// Shared constants for the PIO input conditioner: s1 register addresses,
// edge-mode encodings and the debounce counter width helper.
package pio_cond_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic int cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One conditioned input: 2-flop synchronizer, tick-qualified stability
// counter and the debounced level flop.
module pio_debounce_bit
  import pio_cond_pkg::*;
#(
  parameter int DB_TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic raw_i,
  output logic db_o
);

  localparam int CW = cnt_width(DB_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic          s1_q;
  logic          s2_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      // Any return to the current level throws away the partial count.
      if (s2_q == db_q) begin
        cnt_q <= '0;
      end else if (tick_i) begin
        if (cnt_q == CNT_LAST) begin
          db_q  <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/pio_input_debounce.sv
// Raw key/switch conditioner ahead of the PIO data_in: shared tick prescaler,
// per-bit debounce, edge capture with maskable level IRQ and an s1 slave.
module pio_input_debounce
  import pio_cond_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int TICK_DIV  = 50000,
  parameter int DB_TICKS  = 10,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre_q;
  logic             tick;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic [31:0]      rd_d;
  logic             wr_strobe;
  logic             unused_wdata;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + PW'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_debounce_bit #(
      .DB_TICKS(DB_TICKS)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .tick_i(tick),
      .raw_i (raw_in[g]),
      .db_o  (db_out[g])
    );
  end

  always_comb begin
    ev = '0;
    case (EDGE_MODE)
      EDGE_RISE: ev = db_out & ~db_q;
      EDGE_FALL: ev = ~db_out & db_q;
      default:   ev = db_out ^ db_q;
    endcase
  end

  assign wr_strobe    = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:WIDTH];

  always_comb begin
    cap_d = cap_q;
    if (wr_strobe && (address == ADDR_EDGE)) begin
      cap_d = cap_d & ~writedata[WIDTH-1:0];
    end
    // Applied after the clear so a coincident edge is never lost.
    cap_d = cap_d | ev;

    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d[WIDTH-1:0] = db_out;
      ADDR_MASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rd_d[WIDTH-1:0] = cap_q;
      default:   rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_q     <= '0;
      cap_q    <= '0;
      mask_q   <= '0;
      readdata <= '0;
    end else begin
      db_q     <= db_out;
      cap_q    <= cap_d;
      readdata <= rd_d;
      if (wr_strobe && (address == ADDR_MASK)) begin
        mask_q <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_input_debounce.sv
// Directed bench for pio_input_debounce with a short tick (TICK_DIV=4, DB_TICKS=3).
module tb_pio_input_debounce;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] raw_in;
  logic [15:0] db_out;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  pio_input_debounce #(
    .WIDTH(16), .TICK_DIV(4), .DB_TICKS(3), .EDGE_MODE(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .db_out    (db_out),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [0:NV-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int n, input int lo, input int hi);
    total++;
    if (n < lo || n > hi) begin
      bad++;
      $display("FAIL %s: took %0d clk, allowed %0d..%0d", name, n, lo, hi);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wait_db(input logic [15:0] m, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      n++;
      if ((db_out & m) == m) break;
    end
  endtask

  int n;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'd0, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 1'b1, 3'd4, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 1'b1, 3'd5, 32'h0,         32'h0};
    vecs[6]  = '{1'b0, 1'b1, 3'd6, 32'h0,         32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'd7, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'd2, 32'hFFFF_ABCD, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'd2, 32'h0,         32'h0000_ABCD};
    vecs[10] = '{1'b1, 1'b0, 3'd0, 32'h0000_FFFF, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'd1, 32'h0000_1234, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'd4, 32'h0000_5555, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 3'd2, 32'h0,         32'h0000_ABCD};
    vecs[14] = '{1'b0, 1'b0, 3'd2, 32'h0000_1111, 32'h0000_ABCD};
    vecs[15] = '{1'b0, 1'b1, 3'd2, 32'h0,         32'h0000_ABCD};
    vecs[16] = '{1'b1, 1'b0, 3'd2, 32'h0,         32'h0000_ABCD};
    vecs[17] = '{1'b0, 1'b1, 3'd2, 32'h0,         32'h0};
    vecs[18] = '{1'b1, 1'b0, 3'd3, 32'h0000_FFFF, 32'h0};
    vecs[19] = '{1'b0, 1'b1, 3'd3, 32'h0,         32'h0};

    reset = 1'b1; raw_in = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    @(negedge clk);
    idle();
    check("rst_db", {16'h0, db_out}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rd", readdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d", i), readdata, vecs[i].exp_rd);
    end
    check("vec_irq", {31'h0, irq}, 32'h0);
    check("vec_db", {16'h0, db_out}, 32'h0);

    // Key press on bit 0: 2 sync clocks plus 3 ticks.
    raw_in[0] = 1'b1;
    wait_db(16'h0001, n);
    check("s2_db", {16'h0, db_out}, 32'h0001);
    check_lat("s2_lat", n, 11, 14);
    idle();
    bus(1'b0, 1'b1, 3'd3, 32'h0);
    check("s2_cap", readdata, 32'h0001);

    // Two-tick glitches on bit 3, twice, must not qualify.
    for (int p = 0; p < 2; p++) begin
      raw_in[3] = 1'b1;
      repeat (8) idle();
      raw_in[3] = 1'b0;
      repeat (20) idle();
      check($sformatf("s3_db%0d", p), {16'h0, db_out}, 32'h0001);
    end
    bus(1'b0, 1'b1, 3'd3, 32'h0);
    check("s3_cap", readdata, 32'h0001);

    bus(1'b1, 1'b0, 3'd2, 32'h0001);
    check("s4_irq_on", {31'h0, irq}, 32'h1);
    bus(1'b1, 1'b0, 3'd3, 32'h0001);
    check("s4_irq_off", {31'h0, irq}, 32'h0);
    bus(1'b0, 1'b1, 3'd3, 32'h0);
    check("s4_cap", readdata, 32'h0);

    // W1C of bit 5 on the same clock its edge is captured.
    bus(1'b1, 1'b0, 3'd2, 32'h0021);
    raw_in[5] = 1'b1;
    wait_db(16'h0020, n);
    check("s5_db", {16'h0, db_out}, 32'h0021);
    bus(1'b1, 1'b0, 3'd3, 32'h0020);
    check("s5_irq", {31'h0, irq}, 32'h1);
    bus(1'b0, 1'b1, 3'd3, 32'h0);
    check("s5_cap", readdata, 32'h0020);
    bus(1'b1, 1'b0, 3'd3, 32'h0020);
    check("s5_clr_irq", {31'h0, irq}, 32'h0);

    // Reset mid-count, then full re-qualification.
    raw_in = 16'hFFFF;
    repeat (6) idle();
    reset = 1'b1;
    idle();
    check("s6_rst_db", {16'h0, db_out}, 32'h0);
    check("s6_rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    wait_db(16'hFFFF, n);
    check("s6_db", {16'h0, db_out}, 32'h0000_FFFF);
    check_lat("s6_lat", n, 11, 14);
    idle();
    bus(1'b0, 1'b1, 3'd3, 32'h0);
    check("s6_cap", readdata, 32'h0000_FFFF);
    check("s6_irq", {31'h0, irq}, 32'h0);
    bus(1'b0, 1'b1, 3'd2, 32'h0);
    check("s6_mask", readdata, 32'h0);
    bus(1'b1, 1'b0, 3'd2, 32'h8000);
    check("s6_irq_on", {31'h0, irq}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
